btn_ctrl: RTL and testbench
===========================

# btn_ctrl

Parametrised N-channel push-button conditioner for the OrangeCrab `clk48` domain. Each channel has a synchroniser, a debouncer and a press classifier that reports press, short-press and long-press events. One selectable channel drives the board `rst_n` pin low after a configurable hold time, which gives a hold-to-reboot button. Sits between the raw `usr_btn`-style pins and user logic or LED indicators.

## Interface

**Parameters**
- `N_BTN`, 1: number of button channels.
- `ACTIVE_LOW`, 1: 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
- `DEBOUNCE_CYC`, 480000: consecutive stable cycles needed to accept a level change (10 ms at 48 MHz). Must be ≥ 1.
- `LONG_CYC`, 24000000: hold cycles that qualify as a long press (0.5 s). Must be ≥ 2.
- `RESET_CYC`, 33554432: hold cycles on channel `RESET_CH` before `rst_n` asserts (≈0.7 s).
- `RESET_CH`, 0: channel index that drives `rst_n`. Range 0..N_BTN-1.
- `RESET_EN`, 1: 0 = `rst_n` tied high.

**Ports**
- `clk48`, input, 1: the only clock.
- `rst`, input, 1: reset. Synchronous and active-high.
- `btn_in`, input, N_BTN: raw asynchronous button pins.
- `btn_level`, output, N_BTN: debounced state; 1 = pressed, regardless of `ACTIVE_LOW`.
- `press_pulse`, output, N_BTN: one-cycle pulse on each debounced press.
- `short_pulse`, output, N_BTN: one-cycle pulse on release of a press that never reached `LONG_CYC`.
- `long_pulse`, output, N_BTN: one-cycle pulse when a hold reaches `LONG_CYC`, while the button is still pressed.
- `rst_n`, output, 1: board reset request, active-low.

## Operation

**Per-channel pipeline**
- `btn_in` passes through a 2-flop synchroniser.
- The synchronised value is polarity-normalised to `s`, where 1 = pressed.

**Debounce**
- A counter of width `$clog2(DEBOUNCE_CYC+1)` increments while `s != btn_level`.
- It clears to 0 in any cycle where `s == btn_level`.
- When the count reaches `DEBOUNCE_CYC-1` with `s` still differing, `btn_level` toggles on the next edge and the counter clears.
- A glitch shorter than `DEBOUNCE_CYC` cycles never changes `btn_level`.

**Classifier FSM (per channel)**
- States: IDLE, HELD, LONG.
- IDLE → HELD on the rising edge of `btn_level`. `press_pulse` = 1 for that cycle; hold counter loads 1.
- HELD: the hold counter increments each cycle while `btn_level` = 1.
  - When the count equals `LONG_CYC`, `long_pulse` = 1 and the FSM goes to LONG.
  - If `btn_level` falls first, `short_pulse` = 1 and the FSM goes to IDLE.
- LONG: the counter keeps incrementing and saturates at max(`LONG_CYC`, `RESET_CYC`). On `btn_level` fall the FSM goes to IDLE with no pulse.
- The hold counter clears in IDLE.
- Counter width = `$clog2(max(LONG_CYC, RESET_CYC)+1)`. The counter never wraps.

**Reset request**
- On channel `RESET_CH` with `RESET_EN` = 1, `rst_n` goes to 0 once the hold counter reaches `RESET_CYC`.
- `rst_n` stays 0 until that channel's `btn_level` falls, then returns to 1 on the next edge.
- `RESET_CYC` < `LONG_CYC` is legal. `rst_n` behaviour does not depend on the FSM state.

**Reset**
- `rst` forces every output to its reset value:
  - `btn_level`, `press_pulse`, `short_pulse`, `long_pulse` = 0.
  - `rst_n` = 1.
  - All counters = 0. FSMs = IDLE.
  - Synchroniser flops = released.
- A press in progress when `rst` asserts produces no pulse. After reset is released, a still-held button must pass through debounce again before it is seen as pressed.

## Timing

- All outputs are registered.
- Latency from a raw pin change to `btn_level` = 2 + `DEBOUNCE_CYC` cycles, when the pin is stable throughout.
- `press_pulse` is high in the first cycle `btn_level` = 1.
- `short_pulse` is high in the first cycle `btn_level` = 0.
- `long_pulse` is high in cycle `LONG_CYC-1` after `press_pulse`, i.e. the press lasted `LONG_CYC` cycles inclusive.
- `rst_n` falls `RESET_CYC-1` cycles after `press_pulse`.
- If release and the `LONG_CYC` threshold happen in the same cycle, the release wins: `short_pulse` fires and `long_pulse` does not.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses.
- At most one of `press_pulse`, `short_pulse`, `long_pulse` is high per channel per cycle.

## Structure

- Package `btn_ctrl_pkg` holds:
  - the FSM state localparams (IDLE = 2'd0, HELD = 2'd1, LONG = 2'd2);
  - a `max` constant function used for counter widths.
- Sub-module `btn_debounce`: synchroniser, polarity normalisation and debounce counter. It outputs `level` only.
  - Instantiated `N_BTN` times in a generate loop.
  - The classifier FSM and the `rst_n` logic live in `btn_ctrl`.

## Test plan

All scenarios use `N_BTN` = 2, `DEBOUNCE_CYC` = 4, `LONG_CYC` = 16, `RESET_CYC` = 32, `ACTIVE_LOW` = 1.

1. Bounce rejection: drive `btn_in[0]` low for 3 cycles, then high, repeated 5 times → `btn_level[0]` stays 0 and no pulses occur. Then hold low → `btn_level[0]` rises 6 cycles after the pin falls, with `press_pulse[0]` in the same cycle.
2. Short press: hold 10 debounced cycles, then release → exactly one `short_pulse[0]` in the first cycle `btn_level` = 0, and no `long_pulse`.
3. Long press: hold 20 cycles → `long_pulse[0]` exactly 15 cycles after `press_pulse`. Release produces no `short_pulse`.
4. Hold-to-reset: hold channel 0 for 40 cycles → `rst_n` = 0 from 31 cycles after `press_pulse` until 1 cycle after `btn_level` falls. Holding channel 1 for 40 cycles leaves `rst_n` = 1.
5. Reset mid-press: assert `rst` for 1 cycle at hold count 10 while the pin stays low → all outputs return to reset values. `btn_level` re-rises 6 cycles later, with a fresh `press_pulse`.
6. Boundary: release so that `btn_level` falls in the cycle the count reaches 16 → `short_pulse` = 1 and `long_pulse` = 0. A concurrent press on channel 1 still produces `press_pulse[1]`.

Source files
------------

// File: rtl/btn_ctrl_pkg.sv
// Shared types and helpers for the push-button conditioner.
package btn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } cls_state_t;

  function automatic int unsigned max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, polarity normalisation and
// stable-count debouncer producing a clean pressed level.
module btn_debounce #(
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned DEBOUNCE_CYC = 480000
) (
  input  logic clk48,
  input  logic rst,
  input  logic pin,
  output logic level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          s;
  logic [CW-1:0] cnt;

  // Reset parks the synchroniser at the released pin level.
  always_ff @(posedge clk48) begin
    if (rst) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  assign s = ACTIVE_LOW ? ~sync2 : sync2;

  // Level flips only after DEBOUNCE_CYC consecutive disagreeing samples.
  always_ff @(posedge clk48) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (s == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= ~level;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/btn_ctrl.sv
// N-channel button conditioner: debounce, press/short/long classification
// and hold-to-reboot reset request on one selectable channel.
module btn_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned N_BTN        = 1,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned DEBOUNCE_CYC = 480000,
  parameter int unsigned LONG_CYC     = 24000000,
  parameter int unsigned RESET_CYC    = 33554432,
  parameter int unsigned RESET_CH     = 0,
  parameter bit          RESET_EN     = 1'b1
) (
  input  logic             clk48,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] short_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic             rst_n
);

  localparam int unsigned HOLD_MAX = max(LONG_CYC, RESET_CYC);
  localparam int unsigned HW       = $clog2(HOLD_MAX + 1);
  // The hold register counts cycles since the press cycle, i.e. the
  // inclusive press length minus one, so thresholds sit one below.
  localparam logic [HW-1:0] HOLD_SAT = HW'(HOLD_MAX - 1);
  localparam logic [HW-1:0] LONG_AT  = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] RST_AT   = HW'((RESET_CYC > 0) ? RESET_CYC - 1 : 0);

  logic [HW-1:0] rst_cnt;
  logic          rst_hit;
  logic          rst_hold;

  for (genvar ch = 0; ch < N_BTN; ch++) begin : g_ch
    cls_state_t    state;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_inc;
    logic          lvl;

    btn_debounce #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb (
      .clk48(clk48),
      .rst  (rst),
      .pin  (btn_in[ch]),
      .level(lvl)
    );

    assign hold_inc = (hold == HOLD_SAT) ? hold : hold + HW'(1);

    always_ff @(posedge clk48) begin
      if (rst) begin
        state <= IDLE;
        hold  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (lvl) begin
              state <= HELD;
              hold  <= HW'(1);
            end else begin
              hold <= '0;
            end
          end
          HELD: begin
            if (!lvl) begin
              state <= IDLE;
              hold  <= '0;
            end else begin
              if (hold == LONG_AT) state <= LONG;
              hold <= hold_inc;
            end
          end
          LONG: begin
            if (!lvl) begin
              state <= IDLE;
              hold  <= '0;
            end else begin
              hold <= hold_inc;
            end
          end
          default: begin
            state <= IDLE;
            hold  <= '0;
          end
        endcase
      end
    end

    // Pulses decode the registered level and state so each lands in the
    // first cycle of the new level; a release on the long threshold wins.
    assign btn_level[ch]   = lvl;
    assign press_pulse[ch] = lvl && (state == IDLE);
    assign short_pulse[ch] = !lvl && (state == HELD);
    assign long_pulse[ch]  = lvl && (state == HELD) && (hold == LONG_AT);

    if (ch == RESET_CH) begin : g_rst_src
      assign rst_cnt = hold;
    end
  end

  assign rst_hit = RESET_EN && btn_level[RESET_CH] && (rst_cnt >= RST_AT);

  // Keeps the request low through the first released cycle.
  always_ff @(posedge clk48) begin
    if (rst) rst_hold <= 1'b0;
    else     rst_hold <= rst_hit;
  end

  assign rst_n = ~(rst_hit | rst_hold);

endmodule

// File: tb/tb_btn_ctrl.sv
// Directed and randomized bench for btn_ctrl with a behavioural model
// built from pin history windows and press start times.
module tb_btn_ctrl;

  localparam int NB  = 2;
  localparam int DEB = 4;
  localparam int LNG = 16;
  localparam int RST = 32;

  logic          clk48 = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] short_pulse;
  logic [NB-1:0] long_pulse;
  logic          rst_n;

  always #5 clk48 = ~clk48;

  btn_ctrl #(
    .N_BTN       (NB),
    .ACTIVE_LOW  (1'b1),
    .DEBOUNCE_CYC(DEB),
    .LONG_CYC    (LNG),
    .RESET_CYC   (RST),
    .RESET_CH    (0),
    .RESET_EN    (1'b1)
  ) dut (
    .clk48      (clk48),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .press_pulse(press_pulse),
    .short_pulse(short_pulse),
    .long_pulse (long_pulse),
    .rst_n      (rst_n)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [NB-1:0] pins;
  logic [NB-1:0] d1, d2, m_lvl, lvl_prev;
  logic [NB-1:0] exp_press, exp_short, exp_long;
  logic          exp_rstn;
  bit            prev_low;
  bit            s_hist [NB][$];
  int            rise_t [NB];
  int            t = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_step(input logic r);
    bit s, all_diff, low_now;
    if (r) begin
      d1 = '0; d2 = '0; m_lvl = '0; lvl_prev = '0; prev_low = 0;
      for (int ch = 0; ch < NB; ch++) s_hist[ch].delete();
    end else begin
      for (int ch = 0; ch < NB; ch++) begin
        s = d2[ch];
        d2[ch] = d1[ch];
        d1[ch] = ~pins[ch];
        s_hist[ch].push_back(s);
        if (s_hist[ch].size() > DEB) void'(s_hist[ch].pop_front());
        if (s_hist[ch].size() == DEB) begin
          all_diff = 1;
          for (int i = 0; i < DEB; i++)
            if (s_hist[ch][i] == m_lvl[ch]) all_diff = 0;
          if (all_diff) m_lvl[ch] = ~m_lvl[ch];
        end
      end
    end
    for (int ch = 0; ch < NB; ch++) begin
      exp_press[ch] = m_lvl[ch] && !lvl_prev[ch];
      if (exp_press[ch]) rise_t[ch] = t;
      exp_long[ch]  = m_lvl[ch] && (t - rise_t[ch] == LNG - 1);
      exp_short[ch] = !m_lvl[ch] && lvl_prev[ch] && (t - rise_t[ch] < LNG);
    end
    low_now  = m_lvl[0] && (t - rise_t[0] >= RST - 1);
    exp_rstn = !(low_now || prev_low);
    prev_low = low_now;
    lvl_prev = m_lvl;
  endtask

  task automatic tick(input logic r);
    rst    = r;
    btn_in = pins;
    @(posedge clk48);
    #1;
    model_step(r);
    check("btn_level", 32'(btn_level), 32'(m_lvl));
    check("press_pulse", 32'(press_pulse), 32'(exp_press));
    check("short_pulse", 32'(short_pulse), 32'(exp_short));
    check("long_pulse", 32'(long_pulse), 32'(exp_long));
    check("rst_n", 32'(rst_n), 32'(exp_rstn));
    t++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  initial begin
    d1 = '0; d2 = '0; m_lvl = '0; lvl_prev = '0; prev_low = 0;
    rise_t[0] = 0; rise_t[1] = 0;
    pins = 2'b11;
    tick(1'b1);
    tick(1'b1);
    run(4);

    // Bounce rejection, then a settled press released after 10 cycles
    for (int k = 0; k < 5; k++) begin
      pins[0] = 1'b0; run(3);
      pins[0] = 1'b1; run(3);
    end
    pins[0] = 1'b0; run(6 + 10);
    pins[0] = 1'b1; run(12);

    // Long press
    pins[0] = 1'b0; run(6 + 20);
    pins[0] = 1'b1; run(12);

    // Hold-to-reset on channel 0, then a long hold on channel 1
    pins[0] = 1'b0; run(6 + 40);
    pins[0] = 1'b1; run(12);
    pins[1] = 1'b0; run(6 + 40);
    pins[1] = 1'b1; run(12);

    // Reset mid-press with the pin still held
    pins[0] = 1'b0; run(6 + 10);
    tick(1'b1);
    run(20);
    pins[0] = 1'b1; run(12);

    // Release landing on the long threshold, with a concurrent ch1 press
    pins[0] = 1'b0; run(15);
    pins = 2'b01;   run(20);
    pins = 2'b11;   run(12);

    // Randomized segments with occasional resets
    for (int k = 0; k < 80; k++) begin
      pins = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) tick(1'b1);
      run(int'($urandom_range(1, 45)));
    end
    pins = 2'b11;
    run(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
